fetch_decode: RTL and testbench

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode.sv | 114 +++++++++++
 tb/tb_fetch_decode.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Instruction sequencer: fetches a word, decodes its fields for the ALU, strobes
// execute and writeback, then advances or branches the program counter.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [6:0]  HALT_OP  = 7'd127
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [6:0]  alu_instr,
  output logic [2:0]  rd_idx,
  output logic [2:0]  ra_idx,
  output logic [2:0]  rb_idx,
  output logic [15:0] value,
  output logic        highlow,
  output logic        exec_en,
  output logic        wb_en,
  input  logic        addrch,
  input  logic [31:0] naddr,
  output logic [31:0] pc,
  output logic        halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        br_q, br_d;
  logic [29:0] tgt_q, tgt_d;
  logic [6:0]  op;

  // Branch targets are word aligned, so the low two target bits are dropped.
  logic        unused_naddr_lo;
  assign unused_naddr_lo = ^naddr[1:0];

  // Only the ALU (0..7) and compare/branch (8..15) groups may redirect the PC.
  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic [6:0] opc,
                                          input logic taken, input logic [29:0] tgt);
    if (taken && (opc < 7'd16)) next_pc = {tgt, 2'b00};
    else                        next_pc = cur + 32'd4;
  endfunction

  assign op = ir_q[31:25];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (op == HALT_OP) ? S_HALT : S_EXEC;
      S_EXEC: begin
        br_d    = addrch;
        tgt_d   = naddr[31:2];
        state_d = S_WB;
      end
      S_WB: begin
        pc_d    = next_pc(pc_q, op, br_q, tgt_q);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Branch sample registers are only read in WB after being written in EXEC.
  always_ff @(posedge clock) begin
    br_q  <= br_d;
    tgt_q <= tgt_d;
  end

  assign mem_req   = (state_q == S_FETCH);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign exec_en   = (state_q == S_EXEC);
  assign wb_en     = (state_q == S_WB) && (op < 7'd8);
  assign halted    = (state_q == S_HALT);

  // Decoded fields follow the instruction register, which only changes on a fetch ack.
  assign alu_instr = op;
  assign rd_idx    = ir_q[24:22];
  assign ra_idx    = ir_q[21:19];
  assign rb_idx    = ir_q[18:16];
  assign value     = ir_q[15:0];
  assign highlow   = (op == 7'd6);

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed scenarios plus randomized instruction streams
// checked against a per-instruction sequence model of the PC and strobes.
module tb_fetch_decode;
  logic        clock = 1'b0;
  logic        reset, mem_ack, addrch;
  logic [31:0] mem_rdata, naddr;
  logic        mem_req, highlow, exec_en, wb_en, halted;
  logic [31:0] mem_addr, pc;
  logic [6:0]  alu_instr;
  logic [2:0]  rd_idx, ra_idx, rb_idx;
  logic [15:0] value;

  logic        reset1, mem_ack1, addrch1;
  logic [31:0] mem_rdata1, naddr1;
  logic        mem_req1, highlow1, exec_en1, wb_en1, halted1;
  logic [31:0] mem_addr1, pc1;
  logic [6:0]  alu_instr1;
  logic [2:0]  rd_idx1, ra_idx1, rb_idx1;
  logic [15:0] value1;

  int passed = 0;
  int total  = 0;
  logic [31:0] pc_m;

  always #5 clock = ~clock;

  fetch_decode u_dut (
    .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_instr(alu_instr),
    .rd_idx(rd_idx), .ra_idx(ra_idx), .rb_idx(rb_idx), .value(value),
    .highlow(highlow), .exec_en(exec_en), .wb_en(wb_en), .addrch(addrch),
    .naddr(naddr), .pc(pc), .halted(halted)
  );

  fetch_decode #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clock(clock), .reset(reset1), .mem_req(mem_req1), .mem_addr(mem_addr1),
    .mem_ack(mem_ack1), .mem_rdata(mem_rdata1), .alu_instr(alu_instr1),
    .rd_idx(rd_idx1), .ra_idx(ra_idx1), .rb_idx(rb_idx1), .value(value1),
    .highlow(highlow1), .exec_en(exec_en1), .wb_en(wb_en1), .addrch(addrch1),
    .naddr(naddr1), .pc(pc1), .halted(halted1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ack = 1'b0; addrch = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    pc_m = 32'h0;
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] w);
    chk({tag, ".op"},  {25'd0, alu_instr}, {25'd0, w[31:25]});
    chk({tag, ".rd"},  {29'd0, rd_idx},    {29'd0, w[24:22]});
    chk({tag, ".ra"},  {29'd0, ra_idx},    {29'd0, w[21:19]});
    chk({tag, ".rb"},  {29'd0, rb_idx},    {29'd0, w[18:16]});
    chk({tag, ".val"}, {16'd0, value},     {16'd0, w[15:0]});
    chk({tag, ".hl"},  {31'd0, highlow},   {31'd0, (w[31:25] == 7'd6)});
  endtask

  // Entered at a negedge inside FETCH; leaves at a negedge inside the next FETCH.
  task automatic run_instr(input string tag, input logic [31:0] w, input int waits,
                           input logic br, input logic [31:0] tgt);
    logic [6:0] opc;
    opc = w[31:25];
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      chk({tag, ".wait_req"},  {31'd0, mem_req}, 32'd1);
      chk({tag, ".wait_addr"}, mem_addr, pc_m);
      @(negedge clock);
    end
    chk({tag, ".req"},  {31'd0, mem_req}, 32'd1);
    chk({tag, ".addr"}, mem_addr, pc_m);
    mem_ack = 1'b1; mem_rdata = w;
    @(negedge clock);
    // DECODE; a stray ack with a different word must not be latched
    chk({tag, ".dec_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, ".dec_ex"},  {31'd0, exec_en}, 32'd0);
    chk_fields({tag, ".dec"}, w);
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = ~w;
    @(negedge clock);
    mem_ack = 1'b0;
    chk({tag, ".ex_en"}, {31'd0, exec_en}, 32'd1);
    chk({tag, ".ex_wb"}, {31'd0, wb_en},   32'd0);
    chk_fields({tag, ".ex"}, w);
    addrch = br; naddr = tgt;
    @(negedge clock);
    addrch = ~br; naddr = $urandom;
    chk({tag, ".wb_ex"}, {31'd0, exec_en}, 32'd0);
    chk({tag, ".wb_en"}, {31'd0, wb_en},   {31'd0, (opc <= 7'd7)});
    if (br && opc <= 7'd15) pc_m = {tgt[31:2], 2'b00};
    else                    pc_m = pc_m + 32'd4;
    @(negedge clock);
    chk({tag, ".pc"},      pc,                pc_m);
    chk({tag, ".nxt_req"}, {31'd0, mem_req},  32'd1);
    chk({tag, ".nxt_wb"},  {31'd0, wb_en},    32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    reset1 = 1'b1; mem_ack1 = 1'b0; addrch1 = 1'b0; mem_rdata1 = 32'h0; naddr1 = 32'h0;
    mem_rdata = 32'h0; naddr = 32'h0;

    // Reset state
    do_reset();
    chk("rst.req",   {31'd0, mem_req}, 32'd1);
    chk("rst.addr",  mem_addr, 32'h0);
    chk("rst.pc",    pc, 32'h0);
    chk("rst.halt",  {31'd0, halted}, 32'd0);
    chk("rst.ex",    {31'd0, exec_en}, 32'd0);
    chk("rst.wb",    {31'd0, wb_en}, 32'd0);
    chk("rst.op",    {25'd0, alu_instr}, 32'd0);
    chk("rst.val",   {16'd0, value}, 32'd0);

    // Basic ALU op with immediate ack, then delayed ack, then taken compare/branch
    run_instr("basic", 32'h0048_0005, 0, 1'b0, 32'h0);
    chk("basic.pc4", pc, 32'h4);
    run_instr("wait3", {7'd3, 25'h1ABCDE}, 3, 1'b0, 32'h0);
    run_instr("br14", {7'd14, 25'h0123456}, 0, 1'b1, 32'h0000_0103);
    chk("br14.pc", pc, 32'h0000_0100);
    run_instr("loadhi", {7'd6, 25'h0FF00AA}, 1, 1'b0, 32'h0);
    run_instr("alubr", {7'd2, 25'h0000010}, 0, 1'b1, 32'h0000_2222);

    // Randomized stream across ALU, branch and NOP groups
    for (int n = 0; n < 40; n++) begin
      int cls;
      cls = $urandom_range(0, 2);
      w = $urandom;
      case (cls)
        0:       w[31:25] = 7'($urandom_range(0, 7));
        1:       w[31:25] = 7'($urandom_range(8, 15));
        default: w[31:25] = 7'($urandom_range(16, 126));
      endcase
      run_instr("rand", w, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in EXEC alongside a stray ack
    mem_ack = 1'b1; mem_rdata = {7'd1, 25'h0};
    @(negedge clock);
    mem_ack = 1'b0;
    @(negedge clock);
    chk("rexec.pre_ex", {31'd0, exec_en}, 32'd1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = {7'd5, 25'h1};
    @(negedge clock);
    reset = 1'b0; mem_ack = 1'b0;
    chk("rexec.ex",  {31'd0, exec_en}, 32'd0);
    chk("rexec.wb",  {31'd0, wb_en}, 32'd0);
    chk("rexec.req", {31'd0, mem_req}, 32'd1);
    chk("rexec.pc",  pc, 32'h0);
    chk("rexec.op",  {25'd0, alu_instr}, 32'd0);
    pc_m = 32'h0;

    // Halt opcode, stays halted under stray acks, reset recovers
    run_instr("pre_halt", {7'd9, 25'h0}, 0, 1'b0, 32'h0);
    mem_ack = 1'b1; mem_rdata = {7'd127, 25'h0};
    @(negedge clock);
    mem_ack = 1'b0;
    chk("halt.dec_op", {25'd0, alu_instr}, 32'd127);
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      chk("halt.req", {31'd0, mem_req}, 32'd0);
      chk("halt.flag", {31'd0, halted}, 32'd1);
      chk("halt.strobes", {30'd0, exec_en, wb_en}, 32'd0);
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    do_reset();
    chk("halt.rst_flag", {31'd0, halted}, 32'd0);
    chk("halt.rst_pc", pc, 32'h0);
    chk("halt.rst_req", {31'd0, mem_req}, 32'd1);

    // PC wrap on the second instance with a NOP and a taken branch flag
    reset1 = 1'b0;
    chk("wrap.addr", mem_addr1, 32'hFFFF_FFFC);
    chk("wrap.req",  {31'd0, mem_req1}, 32'd1);
    mem_ack1 = 1'b1; mem_rdata1 = {7'd20, 25'h0ABCDEF};
    @(negedge clock);
    mem_ack1 = 1'b0;
    chk("wrap.op", {25'd0, alu_instr1}, 32'd20);
    @(negedge clock);
    chk("wrap.ex", {31'd0, exec_en1}, 32'd1);
    addrch1 = 1'b1; naddr1 = 32'h0000_0055;
    @(negedge clock);
    addrch1 = 1'b0;
    chk("wrap.wb", {31'd0, wb_en1}, 32'd0);
    @(negedge clock);
    chk("wrap.pc", pc1, 32'h0);
    chk("wrap.halt", {31'd0, halted1}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
